// File: rtl/md_issue_ctrl_pkg.sv
// rtl/md_issue_ctrl_pkg.sv - shared MDU func codes, issue FSM states and func helpers
// Purpose: one place for the MDU func encoding shared with EX and the MDU, the
// issue controller state encoding, and small decode helpers.
package md_issue_ctrl_pkg;

  // MDU func codes (4 bits). Codes 12..15 are illegal and treated as no-ops.
  localparam logic [3:0] mulMULT   = 4'd0;
  localparam logic [3:0] mulMULTU  = 4'd1;
  localparam logic [3:0] mulDIV    = 4'd2;
  localparam logic [3:0] mulDIVU   = 4'd3;
  localparam logic [3:0] mulMADD   = 4'd4;
  localparam logic [3:0] mulMADDU  = 4'd5;
  localparam logic [3:0] mulMSUB   = 4'd6;
  localparam logic [3:0] mulMSUBU  = 4'd7;
  localparam logic [3:0] mulSetLO  = 4'd8;
  localparam logic [3:0] mulSetHI  = 4'd9;
  localparam logic [3:0] mdReadHI  = 4'd10;
  localparam logic [3:0] mdReadLO  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } md_state_e;

  // Multi-cycle operations: the MDU goes busy after accepting one of these.
  function automatic logic is_compute(input logic [3:0] func);
    return func <= mulMSUBU;
  endfunction

  function automatic logic is_set(input logic [3:0] func);
    return (func == mulSetLO) || (func == mulSetHI);
  endfunction

  function automatic logic is_read(input logic [3:0] func);
    return (func == mdReadHI) || (func == mdReadLO);
  endfunction

  function automatic logic is_div(input logic [3:0] func);
    return (func == mulDIV) || (func == mulDIVU);
  endfunction

endpackage

// File: rtl/md_issue_ctrl_timeout_cnt.sv
// rtl/md_issue_ctrl_timeout_cnt.sv - saturating cycle counter with clear, enable and terminal flag
// Purpose: counts enabled cycles from zero up to MAX and holds there.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to zero (wins over enable)
//   en_i       : count this cycle
//   hit_o      : this cycle's edge brings the count to MAX
module md_timeout_cnt #(
  parameter int MAX = 31
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V  = W'(MAX);
  localparam logic [W-1:0] LAST_V = W'(MAX - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != MAX_V)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // Flag the increment that lands on MAX so the owner can register it in step
  // with the count itself; once saturated the flag stays low.
  assign hit_o = en_i & (cnt_q == LAST_V);

endmodule

// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - EX-to-MDU issue controller with HI/LO read, stall, div-by-zero and hang flags
// Purpose: accepts HI/LO-class instructions from EX, drives a one-cycle registered
// start with operands to the MDU, stalls EX while the MDU cannot take work or HI/LO
// is not yet valid, and serves MFHI/MFLO reads.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/func/a/b/flush   : EX request (flush kills it this cycle)
//   stall                      : hold EX and upstream
//   rd_data                    : MFHI/MFLO result, valid when a read is accepted
//   mdu_start/func/a/b         : registered issue to the MDU
//   mdu_busy, mdu_hi, mdu_lo   : MDU status and HI/LO
//   div_zero                   : pulse, DIV/DIVU issued with B==0
//   mdu_hang                   : sticky, MDU busy longer than TIMEOUT WAIT cycles
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [3:0]        req_func,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_flush,
  output logic              stall,
  output logic [DATA_W-1:0] rd_data,
  output logic              mdu_start,
  output logic [3:0]        mdu_func,
  output logic [DATA_W-1:0] mdu_a,
  output logic [DATA_W-1:0] mdu_b,
  input  logic              mdu_busy,
  input  logic [DATA_W-1:0] mdu_hi,
  input  logic [DATA_W-1:0] mdu_lo,
  output logic              div_zero,
  output logic              mdu_hang
);

  md_state_e         state_q;
  logic [3:0]        func_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              start_q, div_zero_q, hang_q;
  logic              accept, issue_acc, read_acc, hang_hit;

  // ISSUE always stalls: mdu_busy has not risen yet, so HI/LO cannot be trusted.
  assign stall = req_valid & ~req_flush &
                 ~((state_q == ST_IDLE) | ((state_q == ST_WAIT) & ~mdu_busy));
  assign accept    = req_valid & ~req_flush & ~stall;
  assign issue_acc = accept & (is_compute(req_func) | is_set(req_func));
  assign read_acc  = accept & is_read(req_func);

  assign rd_data = read_acc ? ((req_func == mdReadHI) ? mdu_hi : mdu_lo) : '0;

  // Count only while the MDU holds us in WAIT; cleared during ISSUE.
  md_timeout_cnt #(.MAX(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q == ST_ISSUE),
    .en_i  ((state_q == ST_WAIT) & mdu_busy),
    .hit_o (hang_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      func_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      start_q    <= 1'b0;
      div_zero_q <= 1'b0;
      hang_q     <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      div_zero_q <= 1'b0;
      if (hang_hit) begin
        hang_q <= 1'b1;
      end
      if (issue_acc) begin
        func_q     <= req_func;
        a_q        <= req_a;
        b_q        <= req_b;
        start_q    <= 1'b1;
        div_zero_q <= is_div(req_func) & (req_b == '0);
      end
      case (state_q)
        ST_IDLE:  if (issue_acc) state_q <= ST_ISSUE;
        ST_ISSUE: state_q <= is_compute(func_q) ? ST_WAIT : ST_IDLE;
        ST_WAIT:  if (!mdu_busy) state_q <= issue_acc ? ST_ISSUE : ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign mdu_start = start_q;
  assign mdu_func  = func_q;
  assign mdu_a     = a_q;
  assign mdu_b     = b_q;
  assign div_zero  = div_zero_q;
  assign mdu_hang  = hang_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - scoreboard bench for md_issue_ctrl with a behavioural MDU
module tb_md_issue_ctrl;
  import md_issue_ctrl_pkg::*;

  localparam int DW  = 32;
  localparam int TO  = 31;
  localparam int LAT = 4;

  logic          clk, rst_n;
  logic          req_valid, req_flush;
  logic [3:0]    req_func;
  logic [DW-1:0] req_a, req_b;
  logic          stall, mdu_start, mdu_busy, div_zero, mdu_hang;
  logic [DW-1:0] rd_data, mdu_a, mdu_b, mdu_hi, mdu_lo;
  logic [3:0]    mdu_func;

  md_issue_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_func(req_func), .req_a(req_a), .req_b(req_b),
    .req_flush(req_flush), .stall(stall), .rd_data(rd_data),
    .mdu_start(mdu_start), .mdu_func(mdu_func), .mdu_a(mdu_a), .mdu_b(mdu_b),
    .mdu_busy(mdu_busy), .mdu_hi(mdu_hi), .mdu_lo(mdu_lo),
    .div_zero(div_zero), .mdu_hang(mdu_hang)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MDU: set ops write at the start edge, others go busy LAT cycles
  // and write HI/LO on the edge busy falls.
  logic [31:0] hi_q, lo_q;
  logic [63:0] pend;
  logic        busy_q, force_busy;
  int          mcnt;

  function automatic logic [63:0] mdu_calc(input logic [3:0] f, input logic [31:0] a, b, hi, lo);
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f)
      mulMULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      mulMULTU: return {32'd0, a} * {32'd0, b};
      mulDIV:   if (b == 0) return {hi, lo}; else return {32'(sa % sb), 32'(sa / sb)};
      mulDIVU:  if (b == 0) return {hi, lo}; else return {a % b, a / b};
      default:  return {hi, lo};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0; lo_q <= '0; busy_q <= 1'b0; mcnt <= 0; pend <= '0;
    end else begin
      if (busy_q) begin
        if (mcnt == 1) begin
          hi_q <= pend[63:32]; lo_q <= pend[31:0]; busy_q <= 1'b0;
        end else begin
          mcnt <= mcnt - 1;
        end
      end
      if (mdu_start) begin
        if (mdu_func == mulSetHI) hi_q <= mdu_a;
        else if (mdu_func == mulSetLO) lo_q <= mdu_a;
        else begin
          busy_q <= 1'b1;
          mcnt   <= LAT;
          pend   <= mdu_calc(mdu_func, mdu_a, mdu_b, hi_q, lo_q);
        end
      end
    end
  end

  assign mdu_busy = busy_q | force_busy;
  assign mdu_hi   = hi_q;
  assign mdu_lo   = lo_q;

  // Scoreboard
  typedef struct packed {
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        dz;
  } iss_t;

  iss_t        exp_iss[$];
  logic [31:0] exp_rd[$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_acc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    iss_t e;
    logic [31:0] r;
    if (!rst_n) begin
      prev_acc = 1'b0;
    end else begin
      if (prev_acc || mdu_start) check("start_latency", mdu_start, prev_acc);
      if (mdu_start) begin
        check("start_expected", exp_iss.size() != 0, 1);
        if (exp_iss.size() != 0) begin
          e = exp_iss.pop_front();
          check("issue_func", mdu_func, e.f);
          check("issue_a", mdu_a, e.a);
          check("issue_b", mdu_b, e.b);
          check("div_zero", div_zero, e.dz);
        end
      end else if (div_zero) begin
        check("div_zero_stray", div_zero, 0);
      end
      if (req_valid && !req_flush && !stall && (req_func == mdReadHI || req_func == mdReadLO)) begin
        check("rd_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) begin
          r = exp_rd.pop_front();
          check("rd_data", rd_data, r);
        end
      end
      prev_acc = req_valid && !req_flush && !stall && (req_func <= mulSetHI);
    end
  end

  // Presents a request just after a posedge, holds it until accepted, returns
  // the number of stalled cycles and leaves time at the next posedge + 1.
  task automatic do_req(input logic [3:0] f, input logic [31:0] a, b, output int stalls);
    req_valid = 1'b1; req_flush = 1'b0; req_func = f; req_a = a; req_b = b;
    stalls = 0;
    @(negedge clk);
    while (stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stall) check("req_bound", stall, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic push_iss(input logic [3:0] f, input logic [31:0] a, b, input logic dz);
    iss_t e;
    e.f = f; e.a = a; e.b = b; e.dz = dz;
    exp_iss.push_back(e);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int s;
    rst_n = 1'b0; force_busy = 1'b0;
    req_valid = 1'b0; req_flush = 1'b0; req_func = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_start", mdu_start, 0);
    check("rst_func", mdu_func, 0);
    check("rst_a", mdu_a, 0);
    check("rst_b", mdu_b, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_hang", mdu_hang, 0);
    check("rst_rd_data", rd_data, 0);
    @(posedge clk); #1;

    // MULT 3 * -2, then MFLO immediately, then MFHI
    push_iss(mulMULT, 32'd3, 32'hFFFF_FFFE, 1'b0);
    do_req(mulMULT, 32'd3, 32'hFFFF_FFFE, s);
    check("mult_stalls", s, 0);
    exp_rd.push_back(32'hFFFF_FFFA);
    do_req(mdReadLO, '0, '0, s);
    check("mflo_stalls", s, 1 + LAT);
    exp_rd.push_back(32'hFFFF_FFFF);
    do_req(mdReadHI, '0, '0, s);
    check("mfhi_stalls", s, 0);

    // SetHI then MFHI back to back
    push_iss(mulSetHI, 32'h1234, 32'd0, 1'b0);
    do_req(mulSetHI, 32'h1234, 32'd0, s);
    exp_rd.push_back(32'h1234);
    do_req(mdReadHI, '0, '0, s);
    check("sethi_read_stalls", s, 1);

    // DIVU by zero: pulse, HI/LO unchanged
    push_iss(mulDIVU, 32'd7, 32'd0, 1'b1);
    do_req(mulDIVU, 32'd7, 32'd0, s);
    exp_rd.push_back(32'hFFFF_FFFA);
    do_req(mdReadLO, '0, '0, s);
    check("divz_read_stalls", s, 1 + LAT);
    exp_rd.push_back(32'h1234);
    do_req(mdReadHI, '0, '0, s);

    // MULT followed directly by DIV
    push_iss(mulMULT, 32'd5, 32'd6, 1'b0);
    do_req(mulMULT, 32'd5, 32'd6, s);
    push_iss(mulDIV, 32'd100, 32'd7, 1'b0);
    do_req(mulDIV, 32'd100, 32'd7, s);
    check("div_b2b_stalls", s, 1 + LAT);
    exp_rd.push_back(32'd14);
    do_req(mdReadLO, '0, '0, s);
    exp_rd.push_back(32'd2);
    do_req(mdReadHI, '0, '0, s);

    // Flushed request in IDLE: no stall, no start
    req_valid = 1'b1; req_flush = 1'b1; req_func = mulMULT; req_a = 32'd9; req_b = 32'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_idle_stall", stall, 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_flush = 1'b0;

    // Flush after accept: operation still completes
    push_iss(mulMULT, 32'd2, 32'd3, 1'b0);
    do_req(mulMULT, 32'd2, 32'd3, s);
    req_valid = 1'b1; req_flush = 1'b1; req_func = mulMULT; req_a = 32'd1; req_b = 32'd1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("flush_busy_stall", stall, 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_flush = 1'b0;
    exp_rd.push_back(32'd6);
    do_req(mdReadLO, '0, '0, s);
    check("flush_read_stalls", s, 3);

    // Hang: busy held high; mdu_hang rises in WAIT cycle 31 (first WAIT cycle is 0)
    force_busy = 1'b1;
    push_iss(mulMULT, 32'd1, 32'd1, 1'b0);
    do_req(mulMULT, 32'd1, 32'd1, s);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 30) check("hang_before", mdu_hang, 0);
      if (i == 31) check("hang_set", mdu_hang, 1);
      if (i == 39) check("hang_sticky", mdu_hang, 1);
    end
    #1;
    req_valid = 1'b1; req_func = mulMULT; req_a = 32'd4; req_b = 32'd4;
    #1;
    check("wait_busy_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_hang", mdu_hang, 0);
    check("async_rst_stall_idle", stall, 0);
    check("async_rst_start", mdu_start, 0);
    check("async_rst_func", mdu_func, 0);
    check("async_rst_a", mdu_a, 0);
    req_valid = 1'b0; force_busy = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    exp_rd.push_back(32'd0);
    do_req(mdReadHI, '0, '0, s);
    check("post_rst_read_stalls", s, 0);

    repeat (2) @(negedge clk);
    check("iss_queue_empty", exp_iss.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Issue controller between the EX stage and the multiply/divide unit (MDU). It accepts HI/LO-class instructions from EX and drives the MDU's one-cycle `start` with registered operands. It stalls EX while the MDU cannot accept work or HI/LO is not yet valid, and serves MFHI/MFLO reads. It also flags divide-by-zero and MDU hangs.

## Interface

Parameters:
- `DATA_W`, 32, operand/HI/LO width
- `TIMEOUT`, 31, max cycles in WAIT before `mdu_hang` asserts

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `req_valid` in 1: EX holds a HI/LO-class instruction
- `req_func` in 4: MDU func code (shared encoding), plus `mdReadHI`/`mdReadLO`
- `req_a`, `req_b` in DATA_W: rs/rt values
- `req_flush` in 1: EX instruction killed this cycle
- `stall` out 1: hold EX and all upstream stages
- `rd_data` out DATA_W: MFHI/MFLO result, valid when read accepted
- `mdu_start` out 1: registered start pulse to MDU
- `mdu_func` out 4: registered func
- `mdu_a`, `mdu_b` out DATA_W: registered operands
- `mdu_busy` in 1: MDU busy
- `mdu_hi`, `mdu_lo` in DATA_W: MDU HI/LO
- `div_zero` out 1: one-cycle pulse, DIV/DIVU issued with B==0
- `mdu_hang` out 1: sticky, WAIT exceeded TIMEOUT

## Operation

- States: IDLE, ISSUE, WAIT.
- A request is *accepted* when `req_valid & !req_flush & !stall`.
- `stall = req_valid & !req_flush & !(state==IDLE | (state==WAIT & !mdu_busy))`.
- Flushed requests are ignored entirely: no issue, no stall.
- Accepted compute or set func (MULT..MSUBU, DIV/DIVU, SetHI/SetLO):
  - latch func/A/B into `mdu_*`;
  - next state ISSUE.
- Accepted read func:
  - `rd_data = req_func==mdReadHI ? mdu_hi : mdu_lo`, combinational;
  - state unchanged (WAIT with `!mdu_busy` moves to IDLE).
- ISSUE:
  - `mdu_start=1` for exactly this cycle;
  - `stall=1` for any request;
  - next state WAIT for compute funcs, IDLE for SetHI/SetLO.
- WAIT:
  - while `mdu_busy=1`, stall all requests;
  - when `mdu_busy=0`, accept as in IDLE, otherwise go to IDLE.
- `div_zero` pulses during ISSUE when the func is DIV/DIVU and `mdu_b==0`. HI/LO stay unchanged; this is the MDU's contract.
- An issued operation cannot be cancelled. A flush after acceptance does not affect it.
- Illegal func codes are accepted as no-ops: no ISSUE, no stall.

## Timing

- Reset values: state IDLE; `stall` follows its equation (0 when `req_valid=0`); `mdu_start`, `mdu_func`, `mdu_a`, `mdu_b`, `div_zero`, `mdu_hang` are 0; `rd_data` is 0 unless a read is presented.
- Accept at cycle N, then `mdu_start` high at N+1. The MDU samples it at the N+1→N+2 edge and `mdu_busy` is high from N+2.
- The ISSUE-cycle stall exists because `mdu_busy` is still low during N+1.
- SetHI/SetLO: HI/LO update at the N+1→N+2 edge. A read at N+1 stalls; at N+2 it returns the new value.
- MDU completion: `mdu_busy` falls on the same edge HI/LO are written. A read in that cycle returns the final HI/LO with `stall=0`.
- Back-to-back compute: the second request is accepted in the first WAIT cycle with `mdu_busy=0`.
- Timeout:
  - counter resets on entering WAIT and saturates;
  - `mdu_hang` sets when the count reaches TIMEOUT while still in WAIT;
  - cleared only by reset.
- Reset asserted mid-operation: state IDLE and all registers cleared immediately (asynchronous). The MDU shares `rst_n`.

## Structure

- Shared package holds:
  - MDU func codes (`mulMULT`…`mulSetHI`) plus the new `mdReadHI`, `mdReadLO`;
  - state encoding;
  - a helper function `is_compute(func)`.
- One sub-module, `md_timeout_cnt`: saturating counter with clear, enable and terminal flag.

## Test plan

- Reset, then MULT A=3, B=−2 → `mdu_start` one cycle after accept; an MFLO issued immediately stalls until `mdu_busy` falls, then returns 0xFFFFFFFA; MFHI returns 0xFFFFFFFF.
- SetHI 0x1234 then MFHI back-to-back → stall 1 cycle, then `rd_data`=0x1234.
- DIVU A=7, B=0 → `div_zero` pulses one cycle; HI/LO unchanged on a later read.
- MULT followed directly by DIV → DIV stalls through ISSUE and WAIT, accepted in the cycle `mdu_busy=0`; final LO equals the DIV quotient.
- Request with `req_flush=1` → no `mdu_start`, `stall=0`. Flush after accept → operation still completes.
- Hold `mdu_busy=1` for 40 cycles with TIMEOUT=31 → `mdu_hang` sets at WAIT cycle 31 and stays set. Async `rst_n` mid-WAIT → state IDLE and `mdu_hang`=0 without waiting for a clock edge.
